// File: rtl/fl_mul_arbiter.sv
// fl_mul_arbiter: round-robin sharing of one combinational single-precision
// multiplier between two requesters, with valid/ready on requests and responses.
// fl_mul_32bit: combinational IEEE-754 single multiply, round-to-nearest-even,
// subnormal inputs/outputs flushed to zero.

module fl_mul_32bit (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] p_o
);
    logic        sign;
    logic [7:0]  ea, eb;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [47:0] prod;
    logic [22:0] mant;
    logic        guard, sticky, inc;
    logic [23:0] mant_r;
    logic [9:0]  esum;
    logic [7:0]  eres;

    // Significand product, normalisation, rounding and special-case selection
    always_comb begin
        sign   = a_i[31] ^ b_i[31];
        ea     = a_i[30:23];
        eb     = b_i[30:23];
        a_zero = (ea == 8'd0);
        b_zero = (eb == 8'd0);
        a_inf  = (ea == 8'hFF) && (a_i[22:0] == 23'd0);
        b_inf  = (eb == 8'hFF) && (b_i[22:0] == 23'd0);
        a_nan  = (ea == 8'hFF) && (a_i[22:0] != 23'd0);
        b_nan  = (eb == 8'hFF) && (b_i[22:0] != 23'd0);
        prod   = 48'({1'b1, a_i[22:0]}) * 48'({1'b1, b_i[22:0]});
        if (prod[47]) begin
            mant   = prod[46:24];
            guard  = prod[23];
            sticky = |prod[22:0];
        end else begin
            mant   = prod[45:23];
            guard  = prod[22];
            sticky = |prod[21:0];
        end
        inc    = guard & (sticky | mant[0]);
        mant_r = {1'b0, mant} + {23'd0, inc};
        // Biased exponent sum; rounding carry-out bumps the exponent, mantissa wraps to 0
        esum   = {2'b00, ea} + {2'b00, eb} + {9'd0, prod[47]} + {9'd0, mant_r[23]};
        eres   = esum[7:0] - 8'd127;
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
            p_o = 32'h7FC00000;
        else if (a_inf || b_inf)
            p_o = {sign, 8'hFF, 23'd0};
        else if (a_zero || b_zero)
            p_o = {sign, 31'd0};
        else if (esum <= 10'd127)
            p_o = {sign, 31'd0};
        else if (esum >= 10'd382)
            p_o = {sign, 8'hFF, 23'd0};
        else
            p_o = {sign, eres, mant_r[22:0]};
    end
endmodule

module fl_mul_arbiter #(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_product,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_product,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_e;

    state_e      state_q, state_d;
    logic [31:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic        owner_q, owner_d, prio_q, prio_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;
    logic [31:0] mul_p;
    logic        grant_vld, grant_id, own_rdy;

    fl_mul_32bit u_mul (
        .a_i (op_a_q),
        .b_i (op_b_q),
        .p_o (mul_p)
    );

    // Round-robin pick: preferred requester first, otherwise the other one
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = prio_q;
        if (prio_q ? req1_valid : req0_valid) begin
            grant_vld = 1'b1;
            grant_id  = prio_q;
        end else if (prio_q ? req0_valid : req1_valid) begin
            grant_vld = 1'b1;
            grant_id  = ~prio_q;
        end
        own_rdy = owner_q ? rsp1_ready : rsp0_ready;
    end

    // State register with asynchronous reset discarding any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            owner_q  <= 1'b0;
            prio_q   <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            owner_q  <= owner_d;
            prio_q   <= prio_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // Next-state: accept in IDLE, settle for MUL_LAT cycles, hold until response taken
    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        owner_d  = owner_q;
        prio_d   = prio_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    op_a_d  = grant_id ? req1_a : req0_a;
                    op_b_d  = grant_id ? req1_b : req0_b;
                    owner_d = grant_id;
                    cnt_d   = 4'(MUL_LAT - 1);
                    state_d = CALC;
                end
            end
            CALC: begin
                if (cnt_q == 4'd0) begin
                    result_d = mul_p;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (own_rdy) begin
                    prio_d  = ~owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs; ready is gated by rst_n so nothing is offered while reset is held
    always_comb begin
        req0_ready   = rst_n && (state_q == IDLE) && grant_vld && !grant_id;
        req1_ready   = rst_n && (state_q == IDLE) && grant_vld && grant_id;
        rsp0_valid   = (state_q == RESP) && !owner_q;
        rsp1_valid   = (state_q == RESP) && owner_q;
        rsp0_product = result_q;
        rsp1_product = result_q;
        busy         = (state_q != IDLE);
    end
endmodule

// File: tb/tb_fl_mul_arbiter.sv
// Directed bench for fl_mul_arbiter: vector table of single requests plus
// sequences for round-robin, back-pressure, reset mid-CALC and MUL_LAT=1.

module tb_fl_mul_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0v, r0r, r1v, r1r, s0v, s0r, s1v, s1r, busy;
    logic [31:0] r0a, r0b, r1a, r1b, s0p, s1p;
    logic        l_r0v, l_r0r, l_r1r, l_s0v, l_s0r, l_s1v, l_s1p_unused_dummy, l_busy;
    logic [31:0] l_r0a, l_r0b, l_s0p, l_s1p;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        req;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
    } vec_t;
    vec_t vecs[8];

    always #5 clk = ~clk;

    fl_mul_arbiter #(.MUL_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v), .req0_ready(r0r), .req0_a(r0a), .req0_b(r0b),
        .req1_valid(r1v), .req1_ready(r1r), .req1_a(r1a), .req1_b(r1b),
        .rsp0_valid(s0v), .rsp0_ready(s0r), .rsp0_product(s0p),
        .rsp1_valid(s1v), .rsp1_ready(s1r), .rsp1_product(s1p),
        .busy(busy)
    );

    fl_mul_arbiter #(.MUL_LAT(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(l_r0v), .req0_ready(l_r0r), .req0_a(l_r0a), .req0_b(l_r0b),
        .req1_valid(1'b0), .req1_ready(l_r1r), .req1_a(32'd0), .req1_b(32'd0),
        .rsp0_valid(l_s0v), .rsp0_ready(l_s0r), .rsp0_product(l_s0p),
        .rsp1_valid(l_s1v), .rsp1_ready(1'b0), .rsp1_product(l_s1p),
        .busy(l_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated request through the main instance, response taken at once
    task automatic run_vec(input logic req, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] p);
        int n;
        if (!req) begin r0v = 1'b1; r0a = a; r0b = b; end
        else      begin r1v = 1'b1; r1a = a; r1b = b; end
        #1;
        chk("vec_ready", {30'd0, r1r, r0r}, req ? 32'd2 : 32'd1);
        step();
        r0v = 1'b0; r1v = 1'b0;
        r0a = 32'hDEADBEEF; r1a = 32'hDEADBEEF;
        n = 1;
        while (!(s0v || s1v) && n < 20) begin step(); n++; end
        chk("vec_latency", n, 32'd3);
        chk("vec_valid", {30'd0, s1v, s0v}, req ? 32'd2 : 32'd1);
        chk("vec_product", req ? s1p : s0p, p);
        chk("vec_other_port", req ? s0p : s1p, p);
        s0r = !req; s1r = req;
        step();
        s0r = 1'b0; s1r = 1'b0;
        chk("vec_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cyc, prev;
        vecs[0] = '{1'b0, 32'h40000000, 32'h40400000, 32'h40C00000};
        vecs[1] = '{1'b1, 32'h3FC00000, 32'h3FC00000, 32'h40100000};
        vecs[2] = '{1'b0, 32'hC0000000, 32'h40800000, 32'hC1000000};
        vecs[3] = '{1'b1, 32'h00000000, 32'h40A00000, 32'h00000000};
        vecs[4] = '{1'b0, 32'h3F000000, 32'h3F000000, 32'h3E800000};
        vecs[5] = '{1'b1, 32'h40400000, 32'h40400000, 32'h41100000};
        vecs[6] = '{1'b0, 32'h7F800000, 32'h40000000, 32'h7F800000};
        vecs[7] = '{1'b1, 32'h3F800000, 32'hC0A00000, 32'hC0A00000};

        rst_n = 1'b0;
        r0v = 1'b1; r1v = 1'b1; s0r = 1'b0; s1r = 1'b0;
        r0a = 32'h40000000; r0b = 32'h40400000;
        r1a = 32'h3FC00000; r1b = 32'h3FC00000;
        l_r0v = 1'b0; l_r0a = '0; l_r0b = '0; l_s0r = 1'b0;
        step(); step();
        chk("rst_ready", {30'd0, r1r, r0r}, 32'd0);
        chk("rst_valid", {30'd0, s1v, s0v}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_product0", s0p, 32'd0);
        chk("rst_product1", s1p, 32'd0);

        // Round-robin from reset, both valids held, response ready tied high
        rst_n = 1'b1;
        s0r = 1'b1; s1r = 1'b1;
        #1;
        cyc = 0; prev = 0;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (!(r0r || r1r) && n < 20) begin step(); cyc++; n++; end
            chk("rr_grant", {30'd0, r1r, r0r}, (g % 2) ? 32'd2 : 32'd1);
            if (g > 0) chk("rr_spacing", cyc - prev, 32'd4);
            prev = cyc;
            step(); step(); step(); cyc += 3;
            chk("rr_rsp_valid", {30'd0, s1v, s0v}, (g % 2) ? 32'd2 : 32'd1);
            chk("rr_product", (g % 2) ? s1p : s0p, (g % 2) ? 32'h40100000 : 32'h40C00000);
        end
        r0v = 1'b0; r1v = 1'b0;
        step();
        s0r = 1'b0; s1r = 1'b0;
        chk("rr_done", {31'd0, busy}, 32'd0);

        foreach (vecs[i]) run_vec(vecs[i].req, vecs[i].a, vecs[i].b, vecs[i].p);

        // Back-pressure on requester 0 with requester 1 waiting and pulsing its ready
        r0v = 1'b1; r0a = 32'h40000000; r0b = 32'h40400000;
        step();
        r0v = 1'b0;
        r1v = 1'b1; r1a = 32'h3F800000; r1b = 32'h3F800000;
        step(); step();
        for (int k = 0; k < 5; k++) begin
            s1r = (k % 2 == 0);
            #1;
            chk("bp_valid", {30'd0, s1v, s0v}, 32'd1);
            chk("bp_product", s0p, 32'h40C00000);
            chk("bp_req1_ready", {31'd0, r1r}, 32'd0);
            step();
        end
        s1r = 1'b0;
        s0r = 1'b1;
        step();
        s0r = 1'b0;
        chk("bp_release_busy", {31'd0, busy}, 32'd0);
        chk("bp_next_grant", {30'd0, r1r, r0r}, 32'd2);
        r1v = 1'b0;
        #1;

        // Reset mid-CALC: prio is 1 here, reset must bring it back to 0
        r0v = 1'b1; r0a = 32'h40000000; r0b = 32'h40400000;
        step();
        r0v = 1'b0;
        chk("mc_busy_pre", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mc_busy", {31'd0, busy}, 32'd0);
        chk("mc_valid", {30'd0, s1v, s0v}, 32'd0);
        r0v = 1'b1; r1v = 1'b1;
        #1;
        chk("mc_ready_in_reset", {30'd0, r1r, r0r}, 32'd0);
        r0v = 1'b0; r1v = 1'b0;
        step();
        rst_n = 1'b1;
        s0r = 1'b1; s1r = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("mc_no_stale", {29'd0, busy, s1v, s0v}, 32'd0);
        end
        s0r = 1'b0; s1r = 1'b0;
        r0v = 1'b1; r0a = 32'h3FC00000; r0b = 32'h3FC00000;
        r1v = 1'b1; r1a = 32'h40400000; r1b = 32'h40400000;
        #1;
        chk("mc_prio_reset", {30'd0, r1r, r0r}, 32'd1);
        step();
        r0v = 1'b0; r1v = 1'b0;
        step(); step();
        chk("mc_rsp_valid", {30'd0, s1v, s0v}, 32'd1);
        chk("mc_rsp_product", s0p, 32'h40100000);
        s0r = 1'b1;
        step();
        s0r = 1'b0;

        // MUL_LAT=1 instance
        l_r0v = 1'b1; l_r0a = 32'h40000000; l_r0b = 32'h40400000;
        #1;
        chk("l1_ready", {31'd0, l_r0r}, 32'd1);
        step();
        l_r0v = 1'b0;
        n = 1;
        while (!l_s0v && n < 20) begin step(); n++; end
        chk("l1_latency", n, 32'd2);
        chk("l1_product", l_s0p, 32'h40C00000);
        l_s0r = 1'b1;
        step();
        l_s0r = 1'b0;
        chk("l1_idle", {31'd0, l_busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Quiet otherwise-unused outputs of the MUL_LAT=1 instance
    assign l_s1p_unused_dummy = l_r1r ^ l_s1v ^ (^l_s1p);
endmodule

// File: doc/fl_mul_arbiter.md
# fl_mul_arbiter

Shares one `fl_mul_32bit` single-precision multiplier between two requesters, using round-robin arbitration and valid/ready handshakes on both the request and response sides. Accepted operands are registered and held stable at the multiplier inputs. The multiplier is combinational, so the block treats it as a multi-cycle path of `MUL_LAT` cycles before capturing the product. The block sits between the two FP-issuing units and the shared multiplier instance, which it instantiates internally.

## Interface
- `MUL_LAT`, default 2: cycles allowed for the multiplier to settle. Legal range 1..15; the counter is 4 bits.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req0_valid` input 1: requester 0 has operands.
- `req0_ready` output 1: requester 0 operands accepted this cycle.
- `req0_a`, `req0_b` input 32 each: requester 0 IEEE-754 single operands.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`: same as above, for requester 1.
- `rsp0_valid` output 1: product available for requester 0.
- `rsp0_ready` input 1: requester 0 takes the product.
- `rsp0_product` output 32: product for requester 0.
- `rsp1_valid`, `rsp1_ready`, `rsp1_product`: same as above, for requester 1.
- `busy` output 1: high in CALC or RESP.

## Operation
- Registers:
  - `op_a`, `op_b` (32 each) drive the multiplier inputs.
  - `owner` (1) records the granted requester.
  - `prio` (1) is the preferred requester.
  - `cnt` (4) is the settle counter.
  - `result` (32) holds the captured product.
  - `state` takes the values IDLE, CALC, RESP.
- Reset values:
  - state = IDLE; prio = 0; owner = 0; cnt = 0; op_a = op_b = result = 0.
  - All `reqN_ready`, `rspN_valid` and `busy` outputs = 0; both `rspN_product` = 0.
- IDLE behaviour:
  - Grant goes to requester `prio` if its valid is high, otherwise to the other requester if its valid is high.
  - `reqN_ready` = (state == IDLE) && granted N. This is combinational from valid, and at most one ready is high at a time.
  - On a handshake, latch that requester's a/b into op_a/op_b, set owner = N, load cnt = MUL_LAT-1, and go to CALC.
- CALC behaviour:
  - If cnt == 0, capture the multiplier output into `result` and go to RESP.
  - Otherwise decrement cnt.
- RESP behaviour:
  - `rsp<owner>_valid` = 1. The other response valid is 0.
  - `rsp<owner>_product` = result. Both product ports always show `result`; only valid is qualified.
  - On `rsp<owner>_ready`, set prio = ~owner and return to IDLE.
  - A ready from the non-owner is ignored.
- Product contents: the multiplier output is passed through unmodified. No rounding or special-case logic lives in this block.
- No new request is accepted while busy. A requester may hold valid through CALC and RESP; its operands are sampled only in the handshake cycle.
- A requester may drop valid before it is granted, with no side effects. Operand changes while ungranted are ignored.

## Timing
- A request accepted at edge T gives `rsp_valid` high in cycle T+MUL_LAT+1 (MUL_LAT=2: handshake in cycle 0, response valid in cycle 3).
- If both valids are high in IDLE, only `prio` is granted.
- Minimum spacing between grants is MUL_LAT+2 cycles: handshake, MUL_LAT CALC cycles, and one RESP cycle with ready high.
- A response held by `rsp_ready` = 0 stalls the block indefinitely. `result` and valid must stay stable during the stall.
- The multiplier inputs (op_a/op_b) must stay stable from the handshake edge until the capture edge.
- Reset asserted mid-operation returns the block to IDLE immediately and asynchronously. The in-flight operation is discarded with no response, and prio returns to 0.
- The first request after reset deassertion is accepted only on a clock edge with rst_n high.

## Test plan
- Single request, MUL_LAT=2: req0 a=0x40000000 (2.0), b=0x40400000 (3.0) handshakes at cycle 0 -> rsp0_valid in cycle 3, rsp0_product=0x40C00000; rsp1_valid stays 0.
- Normalisation path: req1 a=b=0x3FC00000 (1.5) -> rsp1_product=0x40100000 (2.25), delivered MUL_LAT+1 cycles after the handshake.
- Round-robin: both valids held high with distinct operands from reset -> grants alternate req0, req1, req0, req1. Each handshake is spaced MUL_LAT+2 cycles apart when rsp_ready is tied high.
- Back-pressure: rsp0_ready=0 for 5 cycles in RESP -> rsp0_valid and rsp0_product are stable; req1_ready stays 0; rsp1_ready pulses are ignored. The response completes on the cycle rsp0_ready rises.
- Reset mid-CALC: pull rst_n low during CALC -> busy, ready and valid go to 0 immediately. After release, no stale response appears; a new request from req0 with req1 also valid is granted to req0 (prio reset).
- MUL_LAT=1 build: 2.0*3.0 -> rsp_valid two cycles after the handshake with 0x40C00000.
